// File: rtl/fifo_wr_arbiter.sv
// Write-side controller for the async FIFO: round-robin arbitration of the single write port,
// binary/Gray write pointer and registered full. Define FIFO_WR_ALMOST_FULL_EN for almost_full.
module fifo_wr_arbiter #(
    parameter int Data_Width = 8,
    parameter int Addr_Width = 8,
    parameter int Depth      = 256,
    parameter int Num_Req    = 4
`ifdef FIFO_WR_ALMOST_FULL_EN
    ,
    parameter int Af_Level   = Depth - 4
`endif
) (
    input  logic                          wr_clk,
    input  logic                          wr_rstn,
    input  logic [Num_Req-1:0]            req_valid,
    input  logic [Num_Req*Data_Width-1:0] req_data,
    output logic [Num_Req-1:0]            req_ready,
    input  logic [Addr_Width:0]           rd_ptr_gray_sync,
    output logic                          wr_en,
    output logic [Addr_Width:0]           wr_addr,
    output logic [Data_Width-1:0]         data_in,
    output logic                          full,
    output logic [Addr_Width:0]           wr_ptr_gray,
`ifdef FIFO_WR_ALMOST_FULL_EN
    output logic                          almost_full,
`endif
    output logic [$clog2(Num_Req)-1:0]    grant_id
);

    localparam int GW = $clog2(Num_Req);
    localparam int AW = Addr_Width;

    if (Depth != (1 << Addr_Width)) begin : g_bad_depth
        $error("Depth must equal 2**Addr_Width");
    end
    if (Addr_Width < 2) begin : g_bad_aw
        $error("Addr_Width must be at least 2");
    end
    if (Num_Req < 2 || Num_Req > 8) begin : g_bad_nr
        $error("Num_Req must be in 2..8");
    end

    logic [GW-1:0] rr_q, rr_d;
    logic [GW-1:0] grant_q, grant_sel;
    logic [AW:0]   wr_addr_q, wr_addr_d;
    logic [AW:0]   wr_gray_q, wr_gray_d;
    logic [AW:0]   full_cmp;
    logic          full_q, full_d;

    // Search upward from rr_q with wrap; with nothing valid the previous grant is held.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        int idx;
        logic found;
        grant_sel = grant_q;
        found     = 1'b0;
        for (int k = 0; k < Num_Req; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= Num_Req) idx = idx - Num_Req;
            if (!found && req_valid[GW'(idx)]) begin
                found     = 1'b1;
                grant_sel = GW'(idx);
            end
        end
    end

    // Reset gates the handshake combinationally so nothing is accepted while wr_rstn is low.
    assign grant_id = wr_rstn ? grant_sel : '0;

    always_comb begin
        req_ready           = '0;
        req_ready[grant_id] = req_valid[grant_id] & ~full_q & wr_rstn;
    end

    assign wr_en = |(req_valid & req_ready);

    always_comb begin
        data_in = '0;
        for (int i = 0; i < Num_Req; i++) begin
            if (GW'(i) == grant_id) data_in = req_data[i*Data_Width +: Data_Width];
        end
    end

    always_comb begin
        wr_addr_d = wr_addr_q + (AW+1)'(wr_en);
        wr_gray_d = wr_addr_d ^ (wr_addr_d >> 1);
        full_cmp  = {~rd_ptr_gray_sync[AW:AW-1], rd_ptr_gray_sync[AW-2:0]};
        full_d    = (wr_gray_d == full_cmp);
        rr_d      = rr_q;
        if (wr_en) rr_d = (grant_sel == GW'(Num_Req - 1)) ? '0 : grant_sel + GW'(1);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge wr_clk or negedge wr_rstn) begin
        if (!wr_rstn) begin
            wr_addr_q <= '0;
            wr_gray_q <= '0;
            full_q    <= 1'b0;
            rr_q      <= '0;
            grant_q   <= '0;
        end else begin
            wr_addr_q <= wr_addr_d;
            wr_gray_q <= wr_gray_d;
            full_q    <= full_d;
            rr_q      <= rr_d;
            grant_q   <= grant_sel;
        end
    end

    assign wr_addr     = wr_addr_q;
    assign wr_ptr_gray = wr_gray_q;
    assign full        = full_q;

`ifdef FIFO_WR_ALMOST_FULL_EN
    logic [AW:0] rd_bin;
    logic [AW:0] occupancy;
    logic        af_q;

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        rd_bin = '0;
        for (int i = 0; i <= AW; i++) begin
            rd_bin[i] = ^(rd_ptr_gray_sync >> i);
        end
        occupancy = wr_addr_d - rd_bin;
    end

    always_ff @(posedge wr_clk or negedge wr_rstn) begin
        if (!wr_rstn) af_q <= 1'b0;
        else          af_q <= (occupancy >= (AW+1)'(Af_Level));
    end

    assign almost_full = af_q;
`endif

endmodule
